// File: rtl/lut_target_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lut_enc_pkg
//  Description : Shared sizes and types for the LUT target encoder (reverse
//                lookup of a target value to the LUT index holding it).
//                Default geometry: 32 entries, 5-bit index, 16-bit targets.
//  Revision    : 1.0 - initial release
// ============================================================================
package lut_enc_pkg;

  localparam int LUT_DEPTH  = 32;
  localparam int LUT_IDX_W  = 5;
  localparam int LUT_DATA_W = 16;

  // Search controller states: IDLE waits for start, SCAN walks the table.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } enc_state_t;

  typedef logic [LUT_DATA_W-1:0] lut_word_t;

endpackage
`default_nettype wire

// File: rtl/lut_target_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : lut_target_encoder_if
//  Description : Bus bundle between a client (loader / debug path) and the
//                LUT target encoder.
//    wr_en/wr_addr/wr_data : table write port, one entry per cycle
//    clear_all             : invalidate every entry at the next edge
//    start/key             : search request and the value to find
//    busy                  : search in progress
//    done/hit/index        : one-cycle registered result
//  Modports    : master (client side), slave (encoder side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface lut_target_encoder_if
  import lut_enc_pkg::*;
#(
  parameter int IDX_W  = LUT_IDX_W,
  parameter int DATA_W = LUT_DATA_W
);

  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clear_all;
  logic              start;
  logic [DATA_W-1:0] key;
  logic              busy;
  logic              done;
  logic              hit;
  logic [IDX_W-1:0]  index;

  modport master (
    output wr_en, wr_addr, wr_data, clear_all, start, key,
    input  busy, done, hit, index
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clear_all, start, key,
    output busy, done, hit, index
  );

endinterface
`default_nettype wire

// File: rtl/lut_target_store.sv
`default_nettype none
// ============================================================================
//  Module      : lut_target_store
//  Description : Entry array plus per-entry valid bits for the LUT target
//                encoder. Synchronous write, asynchronous read.
//    Clk, Reset_n          : clock, async active-low reset (valid bits only)
//    wr_en/wr_addr/wr_data : write one entry, marking it valid
//    clear_all             : invalidate all entries; wins over wr_en
//    rd_addr               : scan pointer
//    rd_data/rd_valid      : pre-edge contents of entry rd_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_target_store
  import lut_enc_pkg::*;
#(
  parameter int DEPTH  = LUT_DEPTH,
  parameter int IDX_W  = LUT_IDX_W,
  parameter int DATA_W = LUT_DATA_W
) (
  input  wire logic              Clk,
  input  wire logic              Reset_n,
  input  wire logic              wr_en,
  input  wire logic [IDX_W-1:0]  wr_addr,
  input  wire logic [DATA_W-1:0] wr_data,
  input  wire logic              clear_all,
  input  wire logic [IDX_W-1:0]  rd_addr,
  output logic      [DATA_W-1:0] rd_data,
  output logic                   rd_valid
);

  // Data storage is deliberately not reset: validity is tracked separately,
  // so stale data can never produce a match.
  logic [DATA_W-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic              entry_we;

  // A write coinciding with clear_all is dropped entirely.
  always_comb begin
    entry_we = wr_en && !clear_all;
    valid_d  = valid_q;
    if (clear_all) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (entry_we) begin
      entry_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data  = entry_q[rd_addr];
  assign rd_valid = valid_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/lut_target_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : lut_target_encoder
//  Description : Reverse lookup for the branch/constant LUT. Given a target
//                value, scans the table upward from entry 0 and reports the
//                lowest index holding it (start/done handshake).
//    Clk     : rising-edge clock
//    Reset_n : asynchronous active-low reset
//    bus     : lut_target_encoder_if.slave (write port, search request,
//              busy, and the registered done/hit/index result)
//  Options     : LUT_LAST_HIT_CACHE_EN - one-entry cache of the last hit;
//                a repeated key answers one edge after start without a scan.
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_target_encoder
  import lut_enc_pkg::*;
#(
  parameter int DEPTH  = LUT_DEPTH,
  parameter int IDX_W  = LUT_IDX_W,   // must equal clog2(DEPTH)
  parameter int DATA_W = LUT_DATA_W
) (
  input  wire logic             Clk,
  input  wire logic             Reset_n,
  lut_target_encoder_if.slave   bus
);

  enc_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q,   ptr_d;
  logic [DATA_W-1:0] key_q,   key_d;
  logic              done_q,  done_d;
  logic              hit_q,   hit_d;
  logic [IDX_W-1:0]  index_q, index_d;

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              entry_match;
  logic              last_entry;
  logic              cache_hit;

  lut_target_store #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_store (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .clear_all (bus.clear_all),
    .rd_addr   (ptr_q),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  // Invalid entries never match, whatever their (possibly unknown) data.
  assign entry_match = rd_valid && (rd_data == key_q);
  // DEPTH is a power of two and IDX_W = clog2(DEPTH), so the scan ends
  // exactly at the top pointer value and never wraps.
  assign last_entry  = (ptr_q == IDX_W'(DEPTH - 1));

`ifdef LUT_LAST_HIT_CACHE_EN
  logic              cache_valid_q, cache_valid_d;
  logic [DATA_W-1:0] cache_key_q,   cache_key_d;
  logic [IDX_W-1:0]  cache_idx_q,   cache_idx_d;
  logic              scan_dirty_q,  scan_dirty_d;
  logic              table_mod;

  assign table_mod = bus.wr_en || bus.clear_all;

  // A table update in the start cycle must be visible to the search, so the
  // cache is bypassed then and a real scan runs.
  assign cache_hit = cache_valid_q && (bus.key == cache_key_q) && !table_mod;

  // scan_dirty marks a scan that overlapped a table update; its result may
  // not reflect the current table, so it is reported but not cached.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_key_d   = cache_key_q;
    cache_idx_d   = cache_idx_q;
    scan_dirty_d  = scan_dirty_q;

    if (state_q == IDLE) begin
      scan_dirty_d = 1'b0;
    end else if (table_mod) begin
      scan_dirty_d = 1'b1;
    end

    if (table_mod) begin
      cache_valid_d = 1'b0;
    end else if ((state_q == SCAN) && entry_match && !scan_dirty_q) begin
      cache_valid_d = 1'b1;
      cache_key_d   = key_q;
      cache_idx_d   = ptr_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cache_valid_q <= 1'b0;
      cache_key_q   <= '0;
      cache_idx_q   <= '0;
      scan_dirty_q  <= 1'b0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_key_q   <= cache_key_d;
      cache_idx_q   <= cache_idx_d;
      scan_dirty_q  <= scan_dirty_d;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Next-state and result logic. Result registers default to zero so that
  // done/hit/index form a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    key_d   = key_q;
    done_d  = 1'b0;
    hit_d   = 1'b0;
    index_d = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cache_hit) begin
            done_d  = 1'b1;
            hit_d   = 1'b1;
`ifdef LUT_LAST_HIT_CACHE_EN
            index_d = cache_idx_q;
`endif
          end else begin
            key_d   = bus.key;
            ptr_d   = '0;
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        if (entry_match) begin
          done_d  = 1'b1;
          hit_d   = 1'b1;
          index_d = ptr_q;
          state_d = IDLE;
        end else if (last_entry) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      key_q   <= '0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      key_q   <= key_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      index_q <= index_d;
    end
  end

  assign bus.busy  = (state_q == SCAN);
  assign bus.done  = done_q;
  assign bus.hit   = hit_q;
  assign bus.index = index_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_target_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lut_target_encoder
//  Description : Self-checking bench for lut_target_encoder. Directed steps
//                followed by randomized writes/searches checked against a
//                plain array model of the table.
//  Options     : LUT_LAST_HIT_CACHE_EN - also exercises the hit cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_target_encoder;
  import lut_enc_pkg::*;

  localparam int DEPTH = 32;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;
  int dones  = 0;

  logic [15:0] model_data  [DEPTH];
  bit          model_valid [DEPTH];

  lut_target_encoder_if #(.IDX_W(5), .DATA_W(16)) bus ();

  lut_target_encoder #(.DEPTH(32), .IDX_W(5), .DATA_W(16)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'(a);
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    model_valid[a] = 1'b1;
    model_data[a]  = d;
  endtask

  task automatic do_clear();
    bus.clear_all = 1'b1;
    tick();
    bus.clear_all = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
  endtask

  task automatic start_search(input logic [15:0] k, input logic exp_busy);
    bus.start = 1'b1;
    bus.key   = k;
    tick();
    bus.start = 1'b0;
    t0 = cyc;
    check("busy_after_start", bus.busy, exp_busy);
  endtask

  // Latency is the number of edges after the start edge at which done is seen.
  task automatic wait_result(input string tag, input logic exp_hit, input int exp_idx, input int exp_lat);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_lat"}, cyc - t0, exp_lat);
    check({tag, "_hit"}, bus.hit, exp_hit);
    check({tag, "_index"}, bus.index, exp_idx);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic pulse_check(input string tag);
    tick();
    check({tag, "_done_drop"}, bus.done, 0);
    check({tag, "_hit_drop"}, bus.hit, 0);
    check({tag, "_index_drop"}, bus.index, 0);
  endtask

  // Lowest valid entry holding k, or -1.
  function automatic int ref_index(input logic [15:0] k);
    for (int i = 0; i < DEPTH; i++)
      if (model_valid[i] && model_data[i] == k) return i;
    return -1;
  endfunction

  task automatic search_ref(input logic [15:0] k, input string tag);
    int r;
    r = ref_index(k);
    start_search(k, 1'b1);
    if (r >= 0) wait_result(tag, 1'b1, r, r + 1);
    else        wait_result(tag, 1'b0, 0, DEPTH);
    pulse_check(tag);
  endtask

  initial begin
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clear_all = 1'b0;
    bus.start     = 1'b0;
    bus.key       = '0;
    for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hit", bus.hit, 0);
    check("rst_index", bus.index, 0);
    Reset_n = 1'b1;
    tick();

    // key 0 against an empty (uninitialised) table never matches
    start_search(16'd0, 1'b1);
    wait_result("key0_uninit", 1'b0, 0, 32);
    pulse_check("key0_uninit");

    // Basic hit
    do_write(3, 16'd61);
    do_write(8, 16'd255);
    start_search(16'd255, 1'b1);
    wait_result("hit255", 1'b1, 8, 9);
    pulse_check("hit255");

    // Full-length miss
    start_search(16'd1234, 1'b1);
    wait_result("miss1234", 1'b0, 0, 32);
    pulse_check("miss1234");

    // Duplicates: lowest index wins; clear_all empties the table
    do_write(5, 16'd63);
    do_write(2, 16'd63);
    start_search(16'd63, 1'b1);
    wait_result("dup63", 1'b1, 2, 3);
    pulse_check("dup63");
    do_clear();
    start_search(16'd63, 1'b1);
    wait_result("cleared63", 1'b0, 0, 32);
    pulse_check("cleared63");

    // clear_all beats a same-cycle write
    bus.clear_all = 1'b1;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd4;
    bus.wr_data   = 16'd777;
    tick();
    bus.clear_all = 1'b0;
    bus.wr_en     = 1'b0;
    start_search(16'd777, 1'b1);
    wait_result("clr_vs_wr", 1'b0, 0, 32);
    pulse_check("clr_vs_wr");

    // start while busy is ignored
    do_write(3, 16'd61);
    do_write(8, 16'd255);
    start_search(16'd255, 1'b1);
    repeat (3) tick();
    bus.start = 1'b1;
    bus.key   = 16'd61;
    tick();
    bus.start = 1'b0;
    wait_result("busy_ignored", 1'b1, 8, 9);
    pulse_check("busy_ignored");
    dones = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    check("no_queued_start", dones, 0);

    // Back-to-back: second start in the done cycle
    do_write(31, 16'd7);
    start_search(16'd61, 1'b1);
    wait_result("b2b_first", 1'b1, 3, 4);
    start_search(16'd255, 1'b1);
    wait_result("b2b_second", 1'b1, 8, 9);
    pulse_check("b2b_second");

    // start and wr_en in the same cycle: search sees the new entry
    bus.start   = 1'b1;
    bus.key     = 16'd99;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd0;
    bus.wr_data = 16'd99;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    model_valid[0] = 1'b1;
    model_data[0]  = 16'd99;
    t0 = cyc;
    check("start_wr_busy", bus.busy, 1);
    wait_result("start_wr", 1'b1, 0, 1);
    pulse_check("start_wr");

    // Writes during a scan at ptr=4: ahead is seen, behind is not
    start_search(16'd22, 1'b1);
    repeat (4) tick();
    do_write(20, 16'd22);
    wait_result("wr_ahead", 1'b1, 20, 21);
    pulse_check("wr_ahead");
    do_write(30, 16'd5);
    start_search(16'd22, 1'b1);
    repeat (4) tick();
    do_write(1, 16'd22);
    wait_result("wr_behind", 1'b1, 20, 21);
    pulse_check("wr_behind");

`ifdef LUT_LAST_HIT_CACHE_EN
    do_write(29, 16'd3);
    start_search(16'd255, 1'b1);
    wait_result("cache_fill", 1'b1, 8, 9);
    pulse_check("cache_fill");
    start_search(16'd255, 1'b0);
    wait_result("cache_hit", 1'b1, 8, 0);
    pulse_check("cache_hit");
    do_write(29, 16'd4);
    start_search(16'd255, 1'b1);
    wait_result("cache_inval", 1'b1, 8, 9);
    pulse_check("cache_inval");
`else
    start_search(16'd255, 1'b1);
    wait_result("repeat_a", 1'b1, 8, 9);
    pulse_check("repeat_a");
    start_search(16'd255, 1'b1);
    wait_result("repeat_b", 1'b1, 8, 9);
    pulse_check("repeat_b");
`endif

    // Reset mid-scan aborts with no done pulse
    start_search(16'd1234, 1'b1);
    repeat (5) tick();
    Reset_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_hit", bus.hit, 0);
    check("midrst_index", bus.index, 0);
    tick();
    Reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
    dones = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    check("midrst_no_done", dones, 0);

    // Randomized writes and searches against the array model
    for (int it = 0; it < 10; it++) begin
      repeat (3) do_write(int'($urandom_range(0, DEPTH - 1)), 16'($urandom_range(0, 7)));
      if (it == 5) do_clear();
      search_ref(16'($urandom_range(0, 9)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
